// File: rtl/rd_ptr_empty_ctrl_pkg.sv
// Shared build-time settings for the read-side pointer/empty controller.
// These are the single source of the default pointer width and the
// almost-empty threshold. The controller imports them and does not redefine them.
package rd_ptr_empty_ctrl_pkg;

  // Pointer width. The MSB is the wrap bit and the lower bits address the RAM.
  localparam int A_LENGTH_DEF = 3;

  // The almost-empty flag asserts when the occupancy is at or below this value.
  localparam int ALMOST_EMPTY_THR_DEF = 1;

endpackage

// File: rtl/rd_ptr_empty_ctrl.sv
// Read-domain pointer and empty/occupancy controller for an asynchronous FIFO.
// It keeps the binary read pointer. It derives empty, almost_empty and level
// from the write pointer after that pointer has been synchronized into rd_clk.
//
// Read handshake: a read is accepted in a cycle only when rd_en=1 and empty=0.
// An accepted read advances the pointer at that edge. It also raises rd_valid
// for exactly one cycle afterwards, so rd_valid lines up with synchronous RAM
// read data. If rd_en=1 while empty=1, the read is dropped and underflow is set.
// underflow stays set until reset.
module rd_ptr_empty_ctrl
  import rd_ptr_empty_ctrl_pkg::*;
#(
  parameter int a_length         = A_LENGTH_DEF,
  parameter int almost_empty_thr = ALMOST_EMPTY_THR_DEF
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [a_length-1:0]   b_wr_ptr_sync,
  output logic [a_length-1:0]   b_rd_ptr,
  output logic [a_length-2:0]   rd_addr,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [a_length-1:0]   level,
  output logic                  underflow
);

  // The threshold is cut to the pointer width so that the compare is all unsigned.
  localparam logic [a_length-1:0] ThrW = a_length'(almost_empty_thr);

  logic                accept;
  logic [a_length-1:0] rd_ptr_next;
  logic [a_length-1:0] level_next;

  // Next-state values: the read increment and any movement of the write
  // pointer are both folded into one modular occupancy.
  always_comb begin
    accept      = 1'b0;
    rd_ptr_next = b_rd_ptr;
    level_next  = '0;
    accept      = rd_en & ~empty;
    rd_ptr_next = b_rd_ptr + {{(a_length-1){1'b0}}, accept};
    level_next  = b_wr_ptr_sync - rd_ptr_next;
  end

  // Registered pointer, flags and occupancy. An asynchronous reset discards any read that is in flight.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      b_rd_ptr     <= '0;
      rd_valid     <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      level        <= '0;
      underflow    <= 1'b0;
    end else begin
      b_rd_ptr     <= rd_ptr_next;
      rd_valid     <= accept;
      empty        <= (rd_ptr_next == b_wr_ptr_sync);
      almost_empty <= (level_next <= ThrW);
      level        <= level_next;
      underflow    <= underflow | (rd_en & empty);
    end
  end

  assign rd_addr = b_rd_ptr[a_length-2:0];

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Self-checking bench for rd_ptr_empty_ctrl (a_length=3, almost_empty_thr=1).
module tb_rd_ptr_empty_ctrl;

  localparam int AL = 3;

  typedef struct {
    logic          rd_en;
    logic [AL-1:0] wr;
    logic [AL-1:0] rd_ptr;
    logic          valid;
    logic          empty;
    logic          ae;
    logic [AL-1:0] level;
    logic          uf;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          rd_en;
  logic [AL-1:0] b_wr_ptr_sync;
  logic [AL-1:0] b_rd_ptr;
  logic [AL-2:0] rd_addr;
  logic          rd_valid;
  logic          empty;
  logic          almost_empty;
  logic [AL-1:0] level;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t exp_q[$];

  rd_ptr_empty_ctrl #(.a_length(AL), .almost_empty_thr(1)) dut (
    .rd_clk       (clk),
    .reset        (reset),
    .rd_en        (rd_en),
    .b_wr_ptr_sync(b_wr_ptr_sync),
    .b_rd_ptr     (b_rd_ptr),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level),
    .underflow    (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit r, input int w, input int p, input bit v,
                              input bit e, input bit a, input int l, input bit u);
    vec_t t;
    t.rd_en = r; t.wr = AL'(w); t.rd_ptr = AL'(p); t.valid = v;
    t.empty = e; t.ae = a; t.level = AL'(l); t.uf = u;
    return t;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, " b_rd_ptr"}, 32'(b_rd_ptr), 0);
    chk({tag, " rd_addr"}, 32'(rd_addr), 0);
    chk({tag, " rd_valid"}, 32'(rd_valid), 0);
    chk({tag, " empty"}, 32'(empty), 1);
    chk({tag, " almost_empty"}, 32'(almost_empty), 1);
    chk({tag, " level"}, 32'(level), 0);
    chk({tag, " underflow"}, 32'(underflow), 0);
  endtask

  // scoreboard: pop the oldest expectation and compare it with the DUT outputs
  task automatic score(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " b_rd_ptr"}, 32'(b_rd_ptr), 32'(e.rd_ptr));
    chk({tag, " rd_addr"}, 32'(rd_addr), 32'(e.rd_ptr[AL-2:0]));
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(e.valid));
    chk({tag, " empty"}, 32'(empty), 32'(e.empty));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(e.ae));
    chk({tag, " level"}, 32'(level), 32'(e.level));
    chk({tag, " underflow"}, 32'(underflow), 32'(e.uf));
  endtask

  // driver: apply one vector, push its expectation, clock, then score
  task automatic drive_step(input vec_t v, input string tag);
    rd_en         = v.rd_en;
    b_wr_ptr_sync = v.wr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    score(tag);
  endtask

  task automatic do_reset();
    rd_en = 1'b0;
    b_wr_ptr_sync = '0;
    reset = 1'b1;
    #3;
    check_reset_vals("reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t t1[10];
  vec_t t2[10];

  initial begin
    // Underflow while empty, then drain three words.
    t1[0] = mk(1, 0, 0, 0, 1, 1, 0, 1);
    t1[1] = mk(1, 0, 0, 0, 1, 1, 0, 1);
    t1[2] = mk(1, 0, 0, 0, 1, 1, 0, 1);
    t1[3] = mk(1, 3, 0, 0, 0, 0, 3, 1);
    t1[4] = mk(1, 3, 1, 1, 0, 0, 2, 1);
    t1[5] = mk(1, 3, 2, 1, 0, 1, 1, 1);
    t1[6] = mk(1, 3, 3, 1, 1, 1, 0, 1);
    t1[7] = mk(1, 3, 3, 0, 1, 1, 0, 1);
    t1[8] = mk(0, 3, 3, 0, 1, 1, 0, 1);
    t1[9] = mk(0, 4, 3, 0, 0, 1, 1, 1);
    // The write pointer jumps by 4. Drain that, then read the last word while a write lands.
    t2[0] = mk(0, 4, 0, 0, 0, 0, 4, 0);
    t2[1] = mk(1, 4, 1, 1, 0, 0, 3, 0);
    t2[2] = mk(1, 4, 2, 1, 0, 0, 2, 0);
    t2[3] = mk(1, 4, 3, 1, 0, 1, 1, 0);
    t2[4] = mk(1, 4, 4, 1, 1, 1, 0, 0);
    t2[5] = mk(0, 4, 4, 0, 1, 1, 0, 0);
    t2[6] = mk(0, 5, 4, 0, 0, 1, 1, 0);
    t2[7] = mk(1, 6, 5, 1, 0, 1, 1, 0);
    t2[8] = mk(1, 6, 6, 1, 1, 1, 0, 0);
    t2[9] = mk(0, 6, 6, 0, 1, 1, 0, 0);

    reset = 1'b1;
    rd_en = 1'b0;
    b_wr_ptr_sync = '0;
    do_reset();
    for (int i = 0; i < 10; i++) drive_step(t1[i], $sformatf("t1[%0d]", i));

    do_reset();
    for (int i = 0; i < 10; i++) drive_step(t2[i], $sformatf("t2[%0d]", i));

    // Asynchronous reset between edges while level=2 and rd_en=1.
    do_reset();
    drive_step(mk(0, 2, 0, 0, 0, 0, 2, 0), "pre_async");
    rd_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    @(posedge clk);
    #1;
    check_reset_vals("async_edge");
    #2;
    reset = 1'b0;
    rd_en = 1'b0;
    drive_step(mk(0, 2, 0, 0, 0, 0, 2, 0), "post_async");
    drive_step(mk(1, 2, 1, 1, 0, 1, 1, 0), "first_read");

    // Wrap: write 12 words and read 12 words, with random pacing and no underflow.
    do_reset();
    begin
      logic [AL-1:0] m_rd, wr_val, nxt, lvl;
      logic          m_empty, acc, wrap_seen;
      int            written, reads, cycles;
      m_rd = '0; wr_val = '0; m_empty = 1'b1;
      written = 0; reads = 0; cycles = 0; wrap_seen = 1'b0;
      while (reads < 12 && cycles < 300) begin
        vec_t v;
        cycles++;
        if (written < 12 && AL'(wr_val - m_rd) < 3'd4 && $urandom_range(0, 1) == 1) begin
          wr_val = wr_val + 1'b1;
          written++;
        end
        v.rd_en = ($urandom_range(0, 2) != 0) && !m_empty;
        acc = v.rd_en;
        nxt = m_rd + AL'(acc);
        lvl = wr_val - nxt;
        if (m_rd == 3'd7 && nxt == 3'd0) wrap_seen = 1'b1;
        v.wr = wr_val; v.rd_ptr = nxt; v.valid = acc;
        v.empty = (lvl == 0); v.ae = (lvl <= 1); v.level = lvl; v.uf = 1'b0;
        drive_step(v, "wrap");
        if (acc) reads++;
        m_rd = nxt;
        m_empty = v.empty;
      end
      chk("wrap reads", 32'(reads), 12);
      chk("wrap seen", 32'(wrap_seen), 1);
    end

    chk("queue drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
